// File: rtl/binary_search_bcd_if.sv
// Bundles the search request, result and RAM read port of binary_search_bcd.
// The host/bench side uses master; the search controller uses slave.
interface binary_search_bcd_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [DATA_W-1:0] target;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              done;
    logic              found;
    logic [ADDR_W-1:0] loc;
    logic [3:0]        loc_tens;
    logic [3:0]        loc_ones;

    modport master (
        output start, target, mem_data,
        input  mem_addr, done, found, loc, loc_tens, loc_ones
    );

    modport slave (
        input  start, target, mem_data,
        output mem_addr, done, found, loc, loc_tens, loc_ones
    );
endinterface

// File: rtl/binary_search_bcd.sv
// Binary search over an ascending-sorted synchronous RAM; reports hit/miss,
// the matching address, and that address split into BCD tens/ones digits.
module binary_search_bcd #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    binary_search_bcd_if.slave  bus,
    output logic [1:0]          dbg_state_o
);
    // Handshake: start is a level request sampled in IDLE; done stays high in
    // DONE for as long as start is held, and the block returns to IDLE one
    // cycle after start is seen low there.
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, CMP = 2'd2, DONE = 2'd3} state_t;

    localparam logic [ADDR_W:0] HI_INIT = (ADDR_W+1)'((1 << ADDR_W) - 1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   lo_q, lo_d, hi_q, hi_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic              found_q, found_d;
    logic [ADDR_W-1:0] loc_q, loc_d;
    logic [3:0]        tens_q, tens_d, ones_q, ones_d;

    logic [ADDR_W+1:0] sum;
    logic [ADDR_W-1:0] mid;
    logic [ADDR_W:0]   mid_ext;
    logic [31:0]       mid_w;

    assign sum     = {1'b0, lo_q} + {1'b0, hi_q};
    assign mid     = ADDR_W'(sum >> 1);
    assign mid_ext = {1'b0, mid};
    assign mid_w   = 32'(mid);

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        target_d = target_q;
        found_d  = found_q;
        loc_d    = loc_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        case (state_q)
            IDLE: begin
                found_d = 1'b0;
                if (bus.start) begin
                    target_d = bus.target;
                    lo_d     = '0;
                    hi_d     = HI_INIT;
                    state_d  = WAIT;
                end
            end
            WAIT: state_d = CMP;
            CMP: begin
                if (bus.mem_data == target_q) begin
                    loc_d   = mid;
                    tens_d  = 4'(mid_w / 32'd10);
                    ones_d  = 4'(mid_w % 32'd10);
                    found_d = 1'b1;
                    state_d = DONE;
                end else begin
                    if (bus.mem_data < target_q) lo_d = mid_ext + 1'b1;
                    else                         hi_d = mid_ext - 1'b1;
                    // lo is 0..depth (unsigned), hi is -1..depth-1 (signed).
                    if ($signed({1'b0, lo_d}) > $signed({hi_d[ADDR_W], hi_d})) begin
                        found_d = 1'b0;
                        loc_d   = '0;
                        tens_d  = '0;
                        ones_d  = '0;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            DONE: begin
                if (!bus.start) begin
                    found_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= HI_INIT;
            target_q <= '0;
            found_q  <= 1'b0;
            loc_q    <= '0;
            tens_q   <= '0;
            ones_q   <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            target_q <= target_d;
            found_q  <= found_d;
            loc_q    <= loc_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
        end
    end

    assign bus.mem_addr = mid;
    assign bus.done     = (state_q == DONE);
    assign bus.found    = found_q;
    assign bus.loc      = loc_q;
    assign bus.loc_tens = tens_q;
    assign bus.loc_ones = ones_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_binary_search_bcd.sv
// Directed bench for binary_search_bcd against a RAM holding mem[i] = 2*i.
module tb_binary_search_bcd;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_vec  = 0;
    int n_miss = 0;

    binary_search_bcd_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    binary_search_bcd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input int f, input int l,
                                input int t, input int o);
        check({tag, ".done"},  int'(bus.done), 1);
        check({tag, ".found"}, int'(bus.found), f);
        check({tag, ".loc"},   int'(bus.loc), l);
        check({tag, ".tens"},  int'(bus.loc_tens), t);
        check({tag, ".ones"},  int'(bus.loc_ones), o);
    endtask

    // Raise start and count edges (including the sampling edge) until done.
    task automatic run_search(input string tag, input int tgt, input int f,
                              input int l, input int t, input int o, input int lat);
        int cyc = 0;
        bus.target = DATA_W'(tgt);
        bus.start  = 1'b1;
        while (!bus.done && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, ".lat"}, cyc, lat);
        check_result(tag, f, l, t, o);
    endtask

    task automatic release_start(input string tag);
        bus.start = 1'b0;
        tick();
        check({tag, ".idle_state"}, int'(dbg_state), 0);
        check({tag, ".idle_done"},  int'(bus.done), 0);
        check({tag, ".idle_found"}, int'(bus.found), 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(2 * i);
        bus.start  = 1'b0;
        bus.target = '0;
        reset      = 1'b1;
        tick();
        tick();
        check("rst.state", int'(dbg_state), 0);
        check("rst.done",  int'(bus.done), 0);
        check("rst.found", int'(bus.found), 0);
        check("rst.loc",   int'(bus.loc), 0);
        check("rst.tens",  int'(bus.loc_tens), 0);
        check("rst.ones",  int'(bus.loc_ones), 0);
        check("rst.addr",  int'(bus.mem_addr), 15);
        reset = 1'b0;
        tick();

        run_search("t30", 30, 1, 15, 1, 5, 3);
        release_start("t30");
        check("t30.loc_held", int'(bus.loc), 15);

        run_search("t0", 0, 1, 0, 0, 0, 11);
        release_start("t0");

        run_search("t31", 31, 0, 0, 0, 0, 11);
        release_start("t31");

        run_search("t255", 255, 0, 0, 0, 0, 13);
        release_start("t255");

        run_search("t62", 62, 1, 31, 3, 1, 13);
        bus.target = 8'd4;
        repeat (3) tick();
        check_result("hold", 1, 31, 3, 1);
        check("hold.state", int'(dbg_state), 3);
        release_start("hold");
        check("hold.loc_idle", int'(bus.loc), 31);

        run_search("t4", 4, 1, 2, 0, 2, 11);
        release_start("t4");

        // Abort a search for 62 while it sits in CMP.
        bus.target = 8'd62;
        bus.start  = 1'b1;
        tick();
        tick();
        check("abort.pre_state", int'(dbg_state), 2);
        reset = 1'b1;
        tick();
        check("abort.state", int'(dbg_state), 0);
        check("abort.done",  int'(bus.done), 0);
        check("abort.found", int'(bus.found), 0);
        check("abort.loc",   int'(bus.loc), 0);
        check("abort.tens",  int'(bus.loc_tens), 0);
        check("abort.ones",  int'(bus.loc_ones), 0);
        reset     = 1'b0;
        bus.start = 1'b0;
        tick();
        run_search("post", 62, 1, 31, 3, 1, 13);
        release_start("post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
